flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Downstream neighbour of the ALU in the WISC-S25 five-stage pipeline.
- Captures the ALU's Z/V/N flag results from the instruction in EX into the architectural flag register.
- Resolves conditional branches (B/BR) in ID against those flags and detects the flag RAW hazard between EX and ID.
- Keeps saturating branch statistics counters for performance analysis.

Parameters:
CNT_W, 16, width of each branch statistics counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX stage holds a live instruction
ex_stall  in  1  EX stage held this cycle; no flag commit
ex_flush  in  1  kill EX instruction; no flag commit
ex_opcode  in  4  opcode of the EX instruction
alu_result  in  16  ALU output (already saturated for ADD/SUB)
alu_pos_ovfl  in  1  ALU positive-overflow indication
alu_neg_ovfl  in  1  ALU negative-overflow indication
id_valid  in  1  ID stage holds a live instruction
id_is_branch  in  1  ID instruction is B (0xC) or BR (0xD)
id_ccc  in  3  branch condition code
flag_z  out  1  registered zero flag
flag_v  out  1  registered overflow flag
flag_n  out  1  registered sign flag
branch_taken  out  1  ID branch resolved taken (combinational)
hazard_stall  out  1  ID must hold one cycle (combinational)
br_count  out  CNT_W  branches resolved
br_taken_count  out  CNT_W  branches resolved taken

Behaviour:
- Reset (async, rst=1): flag_z=flag_v=flag_n=0, br_count=0, br_taken_count=0; combinational outputs follow the rules below with zero flags.
- Commit condition: commit = ex_valid & ~ex_stall & ~ex_flush. ex_flush wins over everything.
- Flag class by ex_opcode:
  - 0x0 ADD, 0x1 SUB: update Z, V, N.
  - 0x2 XOR, 0x4 SLL, 0x5 SRA, 0x6 ROR: update Z only.
  - All other opcodes: no update.
- Next-flag values:
  - Z = (alu_result == 16'h0000), computed on the saturated result.
  - V = alu_pos_ovfl | alu_neg_ovfl.
  - N = alu_result[15].
- Flags register on the rising edge when commit is high and the class permits; flags not in the class hold their value.
- Flag-set in EX: fs_ex = ex_valid & ~ex_flush & (opcode in either updating class).
- Condition codes, evaluated against flags F:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
- Resolution: br_req = id_valid & id_is_branch.
  - If fs_ex and ccc != 111: hazard_stall=1, branch_taken=0.
  - Otherwise: hazard_stall=0 and branch_taken = br_req & cond(registered flags).
- Unconditional branches (ccc=111) never stall.
- Counters advance only on a rising edge where br_req & ~hazard_stall:
  - br_count increments by 1.
  - br_taken_count increments by 1 when branch_taken is high.
  - Both saturate at all-ones and never wrap.
- A stalled branch is counted exactly once, in the cycle it resolves.
- When rst asserts mid-operation, flags and counters clear immediately. The first post-reset branch sees zero flags (NE taken, EQ not taken).

Optional Feature:
FLAG_BYPASS_EN
- Defined: no flag hazard stall; hazard_stall is tied 0.
  - When fs_ex is high, cond() uses the EX next-flag values for the flags in the EX class and registered values for the others.
  - ex_stall does not affect the bypass, since the EX instruction is still older.
- Undefined: one-cycle stall behaviour as in Behaviour.

Test Plan:
1. Reset: rst pulse mid-run after flags=Z1V1N1 and counters nonzero -> all flags 0 and counters 0 immediately, without waiting for a clk edge.
2. ADD commits alu_result=0x0000, no overflow -> Z=1, V=0, N=0. Next, XOR with result 0x8001 -> Z=0, and V/N hold at 0.
3. SUB with alu_pos_ovfl=1, alu_result=0x7FFF -> V=1, N=0, Z=0. A following OV branch (ccc=110) with a non-flag EX instruction -> branch_taken=1, and br_count and br_taken_count each +1.
4. Hazard (macro undefined): ADD result 0x0000 in EX, EQ branch in ID -> hazard_stall=1 for exactly one cycle, then branch_taken=1, and br_count +1 only once.
5. Same as 4 with FLAG_BYPASS_EN defined -> hazard_stall=0 and branch_taken=1 in the same cycle.
6. ex_flush=1 with an ADD producing 0x8000 -> flags unchanged. Then drive 2^CNT_W+3 taken UN branches -> both counters saturate at all-ones.

Source files
------------

// File: rtl/flag_branch_unit_if.sv
// ---------------------------------------------------------------------------
// flag_branch_unit_if
//   Bundle of the EX-side flag inputs, the ID-side branch request and the
//   unit's results, shared between the pipeline (master) and
//   flag_branch_unit (slave).
//
//   Handshake: ex_valid qualifies every ex_* / alu_* field and id_valid
//   qualifies id_is_branch / id_ccc in the same cycle. hazard_stall is the
//   unit's not-ready for ID: while it is high the ID branch must be held
//   unchanged and is neither resolved nor counted. The branch is consumed on
//   a rising edge where id_valid & id_is_branch & ~hazard_stall.
//
//   master : ex_valid, ex_stall, ex_flush, ex_opcode[3:0], alu_result[15:0],
//            alu_pos_ovfl, alu_neg_ovfl, id_valid, id_is_branch, id_ccc[2:0]
//   slave  : flag_z, flag_v, flag_n, branch_taken, hazard_stall,
//            br_count[CNT_W-1:0], br_taken_count[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface flag_branch_unit_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_stall;
  logic             ex_flush;
  logic [3:0]       ex_opcode;
  logic [15:0]      alu_result;
  logic             alu_pos_ovfl;
  logic             alu_neg_ovfl;
  logic             id_valid;
  logic             id_is_branch;
  logic [2:0]       id_ccc;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             branch_taken;
  logic             hazard_stall;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] br_taken_count;

  modport master (
    output ex_valid, ex_stall, ex_flush, ex_opcode, alu_result,
           alu_pos_ovfl, alu_neg_ovfl, id_valid, id_is_branch, id_ccc,
    input  flag_z, flag_v, flag_n, branch_taken, hazard_stall,
           br_count, br_taken_count
  );

  modport slave (
    input  ex_valid, ex_stall, ex_flush, ex_opcode, alu_result,
           alu_pos_ovfl, alu_neg_ovfl, id_valid, id_is_branch, id_ccc,
    output flag_z, flag_v, flag_n, branch_taken, hazard_stall,
           br_count, br_taken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
//   Sits after the ALU in the five-stage pipeline. Commits the Z/V/N flags of
//   the EX instruction into the architectural flag register, resolves B/BR
//   conditions in ID against those flags, detects the EX->ID flag RAW hazard
//   and keeps saturating branch statistics counters.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset (flags and counters to 0)
//     bus  : flag_branch_unit_if.slave (EX/ALU inputs, ID branch request,
//            flags, branch_taken, hazard_stall, counters)
//
//   Build option
//     FLAG_BYPASS_EN : when defined, the EX next-flag values are forwarded
//                      into branch resolution and hazard_stall is tied 0.
//                      When undefined, an ID branch waits one cycle behind a
//                      flag-setting EX instruction.
// ---------------------------------------------------------------------------
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  flag_branch_unit_if.slave bus
);

  // Flag register and counters
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  // EX decode
  logic cls_zvn;     // ADD / SUB : Z, V, N
  logic cls_z;       // XOR / SLL / SRA / ROR : Z only
  logic commit;
  logic fs_ex;
  logic nxt_z, nxt_v, nxt_n;

  // ID resolution
  logic br_req;
  logic eff_z, eff_v, eff_n;
  logic cond_ok;
  logic stall;
  logic taken;
  logic br_adv;

  function automatic logic cond_eval(input logic [2:0] ccc,
                                     input logic z, input logic v,
                                     input logic n);
    logic r;
    r = 1'b0;
    case (ccc)
      3'b000:  r = ~z;                 // NE
      3'b001:  r = z;                  // EQ
      3'b010:  r = ~z & ~n;            // GT
      3'b011:  r = n;                  // LT
      3'b100:  r = z | (~z & ~n);      // GE
      3'b101:  r = n | z;              // LE
      3'b110:  r = v;                  // OV
      default: r = 1'b1;               // UN
    endcase
    return r;
  endfunction

  always_comb begin
    cls_zvn = (bus.ex_opcode == 4'h0) || (bus.ex_opcode == 4'h1);
    cls_z   = (bus.ex_opcode == 4'h2) || (bus.ex_opcode == 4'h4) ||
              (bus.ex_opcode == 4'h5) || (bus.ex_opcode == 4'h6);
    commit  = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush;
    // A stalled EX instruction still owns the flags it is about to write,
    // so fs_ex deliberately ignores ex_stall.
    fs_ex   = bus.ex_valid & ~bus.ex_flush & (cls_zvn | cls_z);
    nxt_z   = (bus.alu_result == 16'h0000);
    nxt_v   = bus.alu_pos_ovfl | bus.alu_neg_ovfl;
    nxt_n   = bus.alu_result[15];
  end

  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (commit && (cls_zvn || cls_z)) z_d = nxt_z;
    if (commit && cls_zvn) begin
      v_d = nxt_v;
      n_d = nxt_n;
    end
  end

  always_comb begin
    br_req = bus.id_valid & bus.id_is_branch;
`ifdef FLAG_BYPASS_EN
    // Forward only the flags the EX instruction actually writes.
    eff_z  = fs_ex ? nxt_z : z_q;
    eff_v  = (fs_ex && cls_zvn) ? nxt_v : v_q;
    eff_n  = (fs_ex && cls_zvn) ? nxt_n : n_q;
    stall  = 1'b0;
`else
    eff_z  = z_q;
    eff_v  = v_q;
    eff_n  = n_q;
    // UN does not read flags, so it never waits.
    stall  = br_req & fs_ex & (bus.id_ccc != 3'b111);
`endif
    cond_ok = cond_eval(bus.id_ccc, eff_z, eff_v, eff_n);
    taken   = br_req & ~stall & cond_ok;
    br_adv  = br_req & ~stall;
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d  = cnt_q;
    tcnt_d = tcnt_q;
    if (br_adv) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (taken && (tcnt_q != {CNT_W{1'b1}})) tcnt_d = tcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      cnt_q  <= '0;
      tcnt_q <= '0;
    end else begin
      z_q    <= z_d;
      v_q    <= v_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign bus.flag_z         = z_q;
  assign bus.flag_v         = v_q;
  assign bus.flag_n         = n_q;
  assign bus.branch_taken   = taken;
  assign bus.hazard_stall   = stall;
  assign bus.br_count       = cnt_q;
  assign bus.br_taken_count = tcnt_q;

endmodule
